iterative_left_shifter: RTL and testbench
=========================================

Name: iterative_left_shifter

Overview:
- Multi-cycle shift-left unit, 1 bit position per clock.
- Counterpart to the combinational right-shift stages: fill direction is left, zero-fill from the LSB.
- Used by the ALU/multicycle datapath when a sequenced shift trades area for latency.
- start/busy/done handshake; result registered and held until the next accepted start.

Parameters:
WIDTH  16  data width in bits
CNT_W  4   shift-count width; max shift = 2^CNT_W - 1

Ports:
clk    input   1        system clock, rising edge
rst    input   1        synchronous, active-high reset
start  input   1        request; sampled only in IDLE
In     input   WIDTH    operand, captured on accepted start
Cnt    input   CNT_W    shift amount, captured on accepted start
Rot    input   1        rotate select, captured on accepted start (see Optional Feature)
busy   output  1        high in SHIFT and DONE states
done   output  1        one-cycle pulse; result valid on Out
Out    output  WIDTH    registered result

Behaviour:
- Reset and power-up state:
  - rst high at a rising edge gives state=IDLE, data reg=0, remaining-count reg=0.
  - Out=0, busy=0, done=0.
  - Reset wins over every other event, including mid-SHIFT and in DONE. The in-flight operation is discarded and no done is issued.
- States are IDLE, SHIFT and DONE. busy and done decode from state, so there are no combinational paths from inputs to outputs.
- IDLE:
  - start=1 at edge E0 loads data<=In, rem<=Cnt, rot_q<=Rot.
  - Next state is DONE if Cnt==0, otherwise SHIFT.
  - start=0 keeps the unit in IDLE with Out unchanged.
- SHIFT, at each edge:
  - data <= {data[WIDTH-2:0], fill}, where fill=0 (or data[WIDTH-1] when rotating, see Optional Feature).
  - rem <= rem-1.
  - If rem==1, next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally.
  - A start asserted during DONE is ignored. It must be held or reasserted in IDLE.
- Latency: done is high in the cycle beginning at edge E0+Cnt.
  - Cnt=0 gives done in the cycle right after the capture edge, with Out=In.
  - Cnt=15 gives done 15 edges after capture.
- Out is driven by the data register.
  - During SHIFT, Out shows intermediate values; consumers sample it only when done=1.
  - After DONE, Out holds the result through IDLE until the next accepted start.
- start during SHIFT/DONE is ignored. In, Cnt and Rot may change freely after capture without affecting the result.
- A new start may be accepted in the first IDLE cycle after DONE. The back-to-back throughput is Cnt+2 cycles per operation.
- Shifting by ≥WIDTH cannot occur with default parameters. If CNT_W is widened, the result simply becomes all zeros (logical) or wraps modulo WIDTH (rotate).

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: when rot_q=1, the SHIFT fill bit is data[WIDTH-1] (rotate left). When rot_q=0 the unit zero-fills.
- Not defined:
  - Rot is still a port but is ignored and rot_q is not instantiated.
  - Fill is always 0.
  - Timing and handshake are identical in both builds.

Test Plan:
- rst=1 for 2 cycles, then In=0x00F1, Cnt=4, start for 1 cycle → busy high from E0+1, done high exactly in cycle E0+4 with Out=0x0F10, busy low the cycle after. Out stays 0x0F10 for 5 further idle cycles.
- In=0xABCD, Cnt=0, start → done in the cycle after capture with Out=0xABCD. Then In=0xFFFF, Cnt=15 → done 15 edges after capture with Out=0x8000.
- In=0x8001, Cnt=1, Rot=1 → Out=0x0003 with SHIFTER_ROTATE_EN; Out=0x0002 without it. Also In=0x1234, Cnt=4, Rot=1 with macro → 0x2341.
- Start In=0x0001, Cnt=8; on cycles 2 and 3 pulse start with In=0xFFFF, Cnt=1 and also change In → these are ignored, done at E0+8 with Out=0x0100, and exactly one done pulse.
- Start In=0x0003, Cnt=10; assert rst at E0+5 → next cycle Out=0, busy=0, done=0, and done never pulses. A fresh start In=0x0003, Cnt=2 afterwards yields 0x000C.
- start held high continuously with Cnt=3, In=0x0001 → an operation is accepted every 5 cycles, each done pulse shows 0x0008, and start is never accepted in SHIFT/DONE.

Source files
------------

// File: rtl/iterative_left_shifter.sv
// Sequenced left shifter: one bit position per clock, start/busy/done handshake.
// Define SHIFTER_ROTATE_EN to let Rot select rotate-left instead of zero fill.
//
// state | meaning
// IDLE  | waiting for start; Out holds the last result
// SHIFT | shifting one bit per clock, rem counts down to 1
// DONE  | one-cycle done pulse, result valid on Out
module iterative_left_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic             Rot,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] rem;
    logic             fill;

`ifdef SHIFTER_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rot_q <= 1'b0;
        end else if (state == IDLE && start) begin
            rot_q <= Rot;
        end
    end

    assign fill = rot_q & data[WIDTH-1];
`else
    // Rot stays on the port so both builds share one pinout.
    logic rot_unused;
    assign rot_unused = Rot;
    assign fill       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            rem   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        data <= In;
                        rem  <= Cnt;
                    end
                end
                SHIFT: begin
                    data <= {data[WIDTH-2:0], fill};
                    rem  <= rem - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (Cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);
    assign Out  = data;

endmodule

// File: tb/tb_iterative_left_shifter.sv
// Directed bench for iterative_left_shifter: vector table plus handshake,
// ignored-start, mid-shift reset and back-to-back sequences.
module tb_iterative_left_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_d;
    logic [3:0]  cnt_d;
    logic        rot_d;
    logic        busy;
    logic        done;
    logic [15:0] out_d;

    int nvec = 0;
    int nmis = 0;

    iterative_left_shifter #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (in_d),
        .Cnt   (cnt_d),
        .Rot   (rot_d),
        .busy  (busy),
        .done  (done),
        .Out   (out_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] in;
        logic [3:0]  cnt;
        logic        rot;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation from IDLE; returns result and edges from capture to done.
    task automatic run_op(input logic [15:0] i, input logic [3:0] c, input logic r,
                          output logic [15:0] res, output int lat);
        start = 1'b1;
        in_d  = i;
        cnt_d = c;
        rot_d = r;
        step();
        start = 1'b0;
        in_d  = 16'h5A5A;
        cnt_d = 4'd9;
        rot_d = ~r;
        lat   = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        res = out_d;
        step();
    endtask

    initial begin
        logic [15:0] res;
        int          lat;
        int          ndone;
        int          first;
        logic [15:0] dout;

        vecs[0] = '{16'hABCD, 4'd0,  1'b0, 16'hABCD};
        vecs[1] = '{16'hFFFF, 4'd15, 1'b0, 16'h8000};
`ifdef SHIFTER_ROTATE_EN
        vecs[2] = '{16'h8001, 4'd1,  1'b1, 16'h0003};
        vecs[3] = '{16'h1234, 4'd4,  1'b1, 16'h2341};
`else
        vecs[2] = '{16'h8001, 4'd1,  1'b1, 16'h0002};
        vecs[3] = '{16'h1234, 4'd4,  1'b1, 16'h2340};
`endif
        vecs[4] = '{16'h8001, 4'd1,  1'b0, 16'h0002};
        vecs[5] = '{16'hA5A5, 4'd7,  1'b0, 16'hD280};
        vecs[6] = '{16'h0001, 4'd15, 1'b0, 16'h8000};

        rst   = 1'b1;
        start = 1'b0;
        in_d  = '0;
        cnt_d = '0;
        rot_d = 1'b0;
        step();
        step();
        check("reset_out",  {16'd0, out_d}, 32'd0);
        check("reset_busy", {31'd0, busy},  32'd0);
        check("reset_done", {31'd0, done},  32'd0);
        rst = 1'b0;
        step();

        // Basic handshake timing, Cnt=4
        start = 1'b1;
        in_d  = 16'h00F1;
        cnt_d = 4'd4;
        step();
        start = 1'b0;
        step();
        check("hs_busy_e1", {31'd0, busy}, 32'd1);
        check("hs_done_e1", {31'd0, done}, 32'd0);
        step();
        step();
        check("hs_done_e3", {31'd0, done}, 32'd0);
        step();
        check("hs_done_e4", {31'd0, done}, 32'd1);
        check("hs_out_e4",  {16'd0, out_d}, 32'h0F10);
        step();
        check("hs_busy_after", {31'd0, busy}, 32'd0);
        check("hs_done_after", {31'd0, done}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hs_hold_out", {16'd0, out_d}, 32'h0F10);
        end

        for (int v = 0; v < 7; v++) begin
            run_op(vecs[v].in, vecs[v].cnt, vecs[v].rot, res, lat);
            check($sformatf("vec%0d_out", v), {16'd0, res}, {16'd0, vecs[v].exp});
            check($sformatf("vec%0d_lat", v), lat, {28'd0, vecs[v].cnt});
        end

        // start pulses during SHIFT are ignored
        start = 1'b1;
        in_d  = 16'h0001;
        cnt_d = 4'd8;
        step();
        start = 1'b0;
        ndone = 0;
        first = -1;
        dout  = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin
                start = 1'b1;
                in_d  = 16'hFFFF;
                cnt_d = 4'd1;
            end
            if (i == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = i;
                    dout  = out_d;
                end
            end
            step();
        end
        check("ign_ndone", ndone, 1);
        check("ign_lat",   first, 8);
        check("ign_out",   {16'd0, dout}, 32'h0100);

        // reset mid-SHIFT discards the operation
        start = 1'b1;
        in_d  = 16'h0003;
        cnt_d = 4'd10;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        check("rst_out",  {16'd0, out_d}, 32'd0);
        check("rst_busy", {31'd0, busy},  32'd0);
        check("rst_done", {31'd0, done},  32'd0);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) ndone++;
            step();
        end
        check("rst_no_done", ndone, 0);
        run_op(16'h0003, 4'd2, 1'b0, res, lat);
        check("rst_fresh_out", {16'd0, res}, 32'h000C);
        check("rst_fresh_lat", lat, 2);

        // start held high: one accept every Cnt+2 = 5 cycles
        start = 1'b1;
        in_d  = 16'h0001;
        cnt_d = 4'd3;
        step();
        for (int i = 0; i < 25; i++) begin
            check($sformatf("b2b_done_%0d", i), {31'd0, done}, {31'd0, (i % 5) == 3});
            check($sformatf("b2b_busy_%0d", i), {31'd0, busy}, {31'd0, (i % 5) != 4});
            if ((i % 5) == 3) check($sformatf("b2b_out_%0d", i), {16'd0, out_d}, 32'h0008);
            step();
        end
        start = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
